mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multiply/divide unit with its HI/LO registers and busy sequencer; sits in the E stage beside the ALU.
- Driven by the decoder's start / MDop / HIwrite / LOwrite outputs.
- Models the fixed multi-cycle latency of mult/div and raises the D-stage stall for any HI/LO-touching instruction while an operation is in flight.
- Exposes HI/LO for mfhi/mflo write-back selection.

Parameters:
- MULT_CYCLES, 5, busy cycles after start for mult/multu (and madd family).
- DIV_CYCLES, 10, busy cycles after start for div/divu.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  E-stage instruction is mult/multu/div/divu; one-cycle pulse.
- MDop  in  3  000 multu, 001 mult, 010 divu, 011 div; 1xx reserved (see Optional Feature).
- HIwrite  in  1  mthi in E.
- LOwrite  in  1  mtlo in E.
- A  in  32  forwarded rs operand in E.
- B  in  32  forwarded rt operand in E.
- D_MD_yes  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in flight.
- stall_md  out  1  stall request to hazard unit.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset, asynchronous and active-high: HI=0, LO=0, cnt=0, busy=0, pending result=0, stall_md=0. Any in-flight operation is discarded and HI/LO are not updated.
- States:
  - IDLE (cnt==0).
  - RUN (cnt!=0).
- IDLE->RUN on start:
  - Latch A, B, MDop.
  - cnt = MULT_CYCLES for MDop[1]==0, DIV_CYCLES for MDop[1]==1.
  - Compute the result from the latched operands into pending {hi,lo}.
- RUN:
  - cnt decrements each cycle.
  - On the cycle cnt goes 1->0, pending is written to HI/LO and the unit returns to IDLE.
  - New HI/LO are visible the cycle after busy falls.
- busy = start | (cnt!=0). For MULT_CYCLES=5, busy is high for 6 consecutive cycles: the start cycle plus 5.
- stall_md = D_MD_yes & busy. The combinational path from start is required so a back-to-back mfhi stalls.
- Arithmetic:
  - multu: {HI,LO} = unsigned 64-bit A*B.
  - mult: {HI,LO} = signed 64-bit A*B.
  - divu: LO = A/B, HI = A%B, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of A.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B==0): operation still runs full DIV_CYCLES with busy asserted, and HI/LO are left unchanged.
- mthi/mtlo: when busy==0, HI<=A or LO<=A at the clock edge, with no latency and no busy.
- HIwrite/LOwrite with busy==1 cannot occur under correct stalling. The write is ignored and flagged by a simulation-only assertion.
- start while cnt!=0: ignored and flagged by assertion.
- start together with HIwrite/LOwrite in the same cycle cannot occur (one E instruction); start takes priority.
- MDop 1xx without the feature: treated as no-op. No busy, no state change.
- HI/LO outputs are register values. mfhi/mflo in E read them directly; the stall guarantees they are final.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MDop 100 maddu, 101 madd, 110 msubu, 111 msub.
  - {HI,LO} <= {HI,LO} ± product, 64-bit wrap-around, signedness per op.
  - Uses MULT_CYCLES.
  - The accumulator base is the HI/LO value at the start cycle.
- Undefined: 1xx codes are no-ops as above, and the accumulate logic is absent.

Decomposition:
- Shared macro header/package md_pkg holds:
  - MDop encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV, MD_MADDU, MD_MADD, MD_MSUBU, MD_MSUB).
  - Default latencies.
  - The 64-bit result width constant.
- One natural sub-module, mdu_calc: combinational {hi,lo} result from op, operands and current HI/LO. Divide-by-zero is signalled via a keep flag.
- mdu_sequencer owns the counter, registers, busy/stall and assertions.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3 -> busy high 6 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE, visible the cycle after busy falls.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 11 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with B=0 -> HI/LO unchanged after 11 busy cycles.
- start then D_MD_yes=1 (mflo) on the next cycle -> stall_md=1 through the cycle cnt reaches 0, then 0; mflo reads the new LO.
- mthi A=0x12345678 while idle -> HI=0x12345678 next edge, busy stays 0. Assert reset during div RUN -> HI/LO=0, busy=0 immediately.
- (MDU_MADD_EN) HI:LO=0:10, madd A=-3, B=4 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE after 6 busy cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//
// Contents:
//   - MDop encodings (MD_MULTU .. MD_MSUB).
//   - Default busy latencies for the multiply and divide families.
//   - Result width of the combined {HI,LO} pair.
//   - Sequencer state type, which is also exported as a debug output.
//
// Optional feature macro: MDU_MADD_EN. When it is defined, the 1xx MDop codes
// are the multiply-accumulate family.
package md_pkg;

    localparam logic [2:0] MD_MULTU = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_MADDU = 3'b100;
    localparam logic [2:0] MD_MADD  = 3'b101;
    localparam logic [2:0] MD_MSUBU = 3'b110;
    localparam logic [2:0] MD_MSUB  = 3'b111;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Width of {HI,LO}.
    localparam int MD_RES_W = 64;

    // Busy counter width. It must hold the larger of the two latencies.
    localparam int CNT_W = 8;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Decoder <-> multiply/divide unit signal bundle.
//
// Signal summary:
//   start     E-stage mult/multu/div/divu (madd family with MDU_MADD_EN), one-cycle pulse
//   MDop[2:0] operation code (see md_pkg)
//   HIwrite   mthi in E;  LOwrite  mtlo in E
//   A, B      forwarded rs / rt operands in E
//   D_MD_yes  D-stage instruction touches the MDU or HI/LO
//   busy      operation in flight (includes the start cycle)
//   stall_md  stall request to the hazard unit
//   HI, LO    architectural HI/LO registers
//
// Handshake: there is no ready/valid pair. start is a single-cycle request
// that is accepted only when the unit is idle. The D stage must hold any
// HI/LO-touching instruction while stall_md is high. That guarantees that
// start, HIwrite and LOwrite never arrive while an operation is in flight.
//
// master: decoder / pipeline side.  slave: the multiply/divide unit.
interface mdu_sequencer_if;

    logic        start;
    logic [2:0]  MDop;
    logic        HIwrite;
    logic        LOwrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_MD_yes;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MDop, HIwrite, LOwrite, A, B, D_MD_yes,
        input  busy, stall_md, HI, LO
    );

    modport slave (
        input  start, MDop, HIwrite, LOwrite, A, B, D_MD_yes,
        output busy, stall_md, HI, LO
    );

endinterface

// File: rtl/mdu_calc.sv
// Combinational result generator for the multiply/divide unit.
//
// Ports:
//   op_i[2:0]   MDop code
//   a_i, b_i    operands
//   hi_i, lo_i  current HI/LO. These are the accumulator base for madd/msub
//               and the value that is kept on divide by zero.
//   res_o[63:0] {hi,lo} result
//   keep_o      1 = leave HI/LO unchanged (divide by zero)
//
// Optional feature macro: MDU_MADD_EN adds the maddu/madd/msubu/msub
// accumulate paths. When it is undefined, those codes give {hi_i,lo_i}.
module mdu_calc
    import md_pkg::*;
(
    input  logic [2:0]          op_i,
    input  logic [31:0]         a_i,
    input  logic [31:0]         b_i,
    input  logic [31:0]         hi_i,
    input  logic [31:0]         lo_i,
    output logic [MD_RES_W-1:0] res_o,
    output logic                keep_o
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        prod_u = {32'b0, a_i} * {32'b0, b_i};
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});

        // A single unsigned divider on operand magnitudes. The signs are
        // restored afterwards: the quotient truncates toward zero and the
        // remainder follows A. 0x80000000 / -1 falls out as 0x80000000 rem 0,
        // because the magnitude 0x80000000 is representable unsigned.
        sgn   = op_i[0];
        mag_a = (sgn && a_i[31]) ? (32'd0 - a_i) : a_i;
        mag_b = (sgn && b_i[31]) ? (32'd0 - b_i) : b_i;
        // A zero divisor is replaced with 1 so that no X propagates. The
        // result is discarded through keep_o in that case.
        q_mag = mag_a / ((mag_b == 32'd0) ? 32'd1 : mag_b);
        r_mag = mag_a % ((mag_b == 32'd0) ? 32'd1 : mag_b);
        quot  = (sgn && (a_i[31] ^ b_i[31])) ? (32'd0 - q_mag) : q_mag;
        rem   = (sgn && a_i[31]) ? (32'd0 - r_mag) : r_mag;

        res_o  = {hi_i, lo_i};
        keep_o = 1'b0;

        case (op_i)
            MD_MULTU: res_o = prod_u;
            MD_MULT:  res_o = prod_s;
            MD_DIVU, MD_DIV: begin
                if (b_i == 32'd0) begin
                    keep_o = 1'b1;
                end else begin
                    res_o = {rem, quot};
                end
            end
`ifdef MDU_MADD_EN
            MD_MADDU: res_o = {hi_i, lo_i} + prod_u;
            MD_MADD:  res_o = {hi_i, lo_i} + prod_s;
            MD_MSUBU: res_o = {hi_i, lo_i} - prod_u;
            MD_MSUB:  res_o = {hi_i, lo_i} - prod_s;
`endif
            default: res_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit for the E stage. It holds HI/LO, sequences the fixed
// multi-cycle latency of mult/div, and raises the D-stage stall.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   md       mdu_sequencer_if.slave: start/MDop/HIwrite/LOwrite/A/B/D_MD_yes in,
//            busy/stall_md/HI/LO out
//   state_o  debug view of the sequencer state (IDLE / RUN)
//
// Parameters: MULT_CYCLES (mult family latency), DIV_CYCLES (div latency).
//
// Optional feature macro: MDU_MADD_EN enables the MDop 1xx multiply-accumulate
// ops. Without it those codes are no-ops: no busy and no state change.
//
// Timing: the result is computed at the start edge and parked in pend_q. It
// is committed on the edge where the counter goes 1->0. busy covers the start
// cycle plus the count, so the new HI/LO are visible the first cycle busy is low.
module mdu_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave md,
    output md_state_e      state_o
);

    md_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic [MD_RES_W-1:0]  pend_q, pend_d;
    logic                 keep_q, keep_d;

    logic                 op_valid;
    logic                 start_ok;
    logic [MD_RES_W-1:0]  calc_res;
    logic                 calc_keep;

`ifdef MDU_MADD_EN
    assign op_valid = 1'b1;
`else
    assign op_valid = ~md.MDop[2];
`endif

    // A start that arrives while running is ignored; the assertion below flags it.
    assign start_ok = md.start & op_valid & (state_q == MD_IDLE);

    mdu_calc u_calc (
        .op_i   (md.MDop),
        .a_i    (md.A),
        .b_i    (md.B),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .res_o  (calc_res),
        .keep_o (calc_keep)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
            keep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            keep_q  <= keep_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        keep_d  = keep_q;

        case (state_q)
            MD_IDLE: begin
                if (start_ok) begin
                    // msub/msubu also have MDop[1] set, so the divide latency
                    // is selected on MDop[2:1] == 01.
                    cnt_d   = (md.MDop[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES)
                                                      : CNT_W'(MULT_CYCLES);
                    pend_d  = calc_res;
                    keep_d  = calc_keep;
                    state_d = MD_RUN;
                end else if (!md.start) begin
                    if (md.HIwrite) hi_d = md.A;
                    if (md.LOwrite) lo_d = md.A;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    if (!keep_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Output logic. busy includes start directly so that an mfhi right
    // behind a mult stalls in the same cycle.
    always_comb begin
        md.busy     = start_ok | (state_q == MD_RUN);
        md.stall_md = md.D_MD_yes & md.busy;
    end

    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
    assign state_o = state_q;

`ifndef SYNTHESIS
    a_no_start_in_run: assert property (@(posedge clk) disable iff (reset)
        md.start |-> (state_q == MD_IDLE))
        else $error("mdu_sequencer: start while an operation is in flight was ignored");

    a_no_mtx_in_run: assert property (@(posedge clk) disable iff (reset)
        (md.HIwrite | md.LOwrite) |-> (state_q == MD_IDLE))
        else $error("mdu_sequencer: mthi/mtlo while busy was ignored");

    a_state_cnt: assert property (@(posedge clk) disable iff (reset)
        (state_q == MD_RUN) == (cnt_q != '0))
        else $error("mdu_sequencer: state and counter disagree");
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vectors, a cycle-level
// behavioural model with a pending-result queue, and literal expectations.
module tb_mdu_sequencer;
    import md_pkg::*;

    logic      clk;
    logic      reset;
    md_state_e dbg_state;

    mdu_sequencer_if mif ();

    mdu_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .md      (mif),
        .state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo;
    int          m_rem;
    logic [64:0] exp_q[$];   // {keep, hi, lo} of the operation in flight

    function automatic bit op_ok(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return !op[2];
`endif
    endfunction

    function automatic int op_lat(input logic [2:0] op);
        return (op == 3'b010 || op == 3'b011) ? 10 : 5;
    endfunction

    function automatic logic [64:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        longint unsigned ua, ub;
        longint          sa, sb;
        int              ia, ib, q, r;
        logic [63:0]     res;
        bit              keep;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        ia = a; ib = b;
        res = {hi, lo};
        keep = 1'b0;
        case (op)
            3'b000: res = ua * ub;
            3'b001: res = sa * sb;
            3'b010: if (b == 0) keep = 1'b1; else res = {a % b, a / b};
            3'b011: begin
                if (b == 0) keep = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q = ia / ib;
                    r = ia % ib;
                    res = {r, q};
                end
            end
`ifdef MDU_MADD_EN
            3'b100: res = {hi, lo} + ua * ub;
            3'b101: res = {hi, lo} + sa * sb;
            3'b110: res = {hi, lo} - ua * ub;
            3'b111: res = {hi, lo} - sa * sb;
`endif
            default: res = {hi, lo};
        endcase
        return {keep, res};
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [64:0] e;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0;
            exp_q.delete();
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e[64]) begin
                    m_hi = e[63:32];
                    m_lo = e[31:0];
                end
            end
        end else if (mif.start) begin
            if (op_ok(mif.MDop)) begin
                exp_q.push_back(model_op(mif.MDop, mif.A, mif.B, m_hi, m_lo));
                m_rem = op_lat(mif.MDop);
            end
        end else begin
            if (mif.HIwrite) m_hi = mif.A;
            if (mif.LOwrite) m_lo = mif.A;
        end
    end

    // Compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = (m_rem > 0) || (mif.start && op_ok(mif.MDop));
        check("cyc_busy",  32'(mif.busy), 32'(exp_busy));
        check("cyc_stall", 32'(mif.stall_md), 32'(exp_busy && mif.D_MD_yes));
        check("cyc_hi",    mif.HI, m_hi);
        check("cyc_lo",    mif.LO, m_lo);
        check("cyc_state", 32'(dbg_state == MD_RUN), 32'(m_rem > 0));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and count busy cycles (start cycle included).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        mif.start = 1'b1; mif.MDop = op; mif.A = a; mif.B = b;
        #1;
        n = mif.busy ? 1 : 0;
        tick();
        mif.start = 1'b0;
        while (mif.busy && n < 64) begin
            n++;
            tick();
        end
        if (n >= 64) check("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] v);
        mif.HIwrite = to_hi; mif.LOwrite = !to_hi; mif.A = v;
        #1;
        check(to_hi ? "mthi_busy" : "mtlo_busy", 32'(mif.busy), 32'd0);
        tick();
        mif.HIwrite = 1'b0; mif.LOwrite = 1'b0;
        #1;
        if (to_hi) check("mthi_hi", mif.HI, v);
        else       check("mtlo_lo", mif.LO, v);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        logic [31:0] hi0, lo0;
        reset = 1'b1;
        mif.start = 1'b0; mif.MDop = 3'b000; mif.HIwrite = 1'b0; mif.LOwrite = 1'b0;
        mif.A = '0; mif.B = '0; mif.D_MD_yes = 1'b0;
        #2;
        check("rst_hi", mif.HI, 32'h0);
        check("rst_lo", mif.LO, 32'h0);
        check("rst_busy", 32'(mif.busy), 32'd0);
        check("rst_stall", 32'(mif.stall_md), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // mult -2 * 3
        run_op(3'b001, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_busy_cycles", 32'(n), 32'd6);
        check("mult_hi", mif.HI, 32'hFFFF_FFFF);
        check("mult_lo", mif.LO, 32'hFFFF_FFFA);

        // multu 0xFFFFFFFF * 2
        run_op(3'b000, 32'hFFFF_FFFF, 32'd2, n);
        check("multu_busy_cycles", 32'(n), 32'd6);
        check("multu_hi", mif.HI, 32'h0000_0001);
        check("multu_lo", mif.LO, 32'hFFFF_FFFE);

        // div -7 / 2
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, n);
        check("div_busy_cycles", 32'(n), 32'd11);
        check("div_lo", mif.LO, 32'hFFFF_FFFD);
        check("div_hi", mif.HI, 32'hFFFF_FFFF);

        // divu by zero: full latency, HI/LO untouched
        run_op(3'b010, 32'd1234, 32'd0, n);
        check("divz_busy_cycles", 32'(n), 32'd11);
        check("divz_lo", mif.LO, 32'hFFFF_FFFD);
        check("divz_hi", mif.HI, 32'hFFFF_FFFF);

        // div overflow corner
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("divov_lo", mif.LO, 32'h8000_0000);
        check("divov_hi", mif.HI, 32'h0);

        // div 7 / -2 and -7 / -2
        run_op(3'b011, 32'd7, 32'hFFFF_FFFE, n);
        check("div_pn_lo", mif.LO, 32'hFFFF_FFFD);
        check("div_pn_hi", mif.HI, 32'h1);
        run_op(3'b011, 32'hFFFF_FFF9, 32'hFFFF_FFFE, n);
        check("div_nn_lo", mif.LO, 32'h3);
        check("div_nn_hi", mif.HI, 32'hFFFF_FFFF);

        // divu large
        run_op(3'b010, 32'hFFFF_FFFF, 32'd16, n);
        check("divu_lo", mif.LO, 32'h0FFF_FFFF);
        check("divu_hi", mif.HI, 32'hF);

        // back-to-back mflo behind mult: stall in start cycle and through the count
        mif.start = 1'b1; mif.MDop = 3'b000; mif.A = 32'd5; mif.B = 32'd6; mif.D_MD_yes = 1'b1;
        #1;
        check("stall_start_cycle", 32'(mif.stall_md), 32'd1);
        n = 1;
        tick();
        mif.start = 1'b0;
        while (mif.stall_md && n < 64) begin
            n++;
            tick();
        end
        check("stall_cycles", 32'(n), 32'd6);
        check("stall_released", 32'(mif.stall_md), 32'd0);
        check("mflo_value", mif.LO, 32'd30);
        mif.D_MD_yes = 1'b0;

        // mthi / mtlo while idle
        mt(1'b1, 32'h1234_5678);
        mt(1'b0, 32'h9ABC_DEF0);
        check("mt_keep_hi", mif.HI, 32'h1234_5678);

`ifdef MDU_MADD_EN
        // madd: 0:10 + (-3 * 4) = -2
        mt(1'b1, 32'h0);
        mt(1'b0, 32'd10);
        run_op(3'b101, 32'hFFFF_FFFD, 32'd4, n);
        check("madd_busy_cycles", 32'(n), 32'd6);
        check("madd_hi", mif.HI, 32'hFFFF_FFFF);
        check("madd_lo", mif.LO, 32'hFFFF_FFFE);
`else
        // reserved op: no busy, no change
        hi0 = mif.HI; lo0 = mif.LO;
        run_op(3'b101, 32'hFFFF_FFFD, 32'd4, n);
        check("noop_busy_cycles", 32'(n), 32'd0);
        tick(); tick();
        check("noop_hi", mif.HI, hi0);
        check("noop_lo", mif.LO, lo0);
`endif

        // reset during div run: immediate clear, result discarded
        mif.start = 1'b1; mif.MDop = 3'b011; mif.A = 32'd100; mif.B = 32'd7;
        tick();
        mif.start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("rstrun_hi", mif.HI, 32'h0);
        check("rstrun_lo", mif.LO, 32'h0);
        check("rstrun_busy", 32'(mif.busy), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("rstrun_hi_after", mif.HI, 32'h0);
        check("rstrun_lo_after", mif.LO, 32'h0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

endmodule
